// File: rtl/sram_arbiter.sv
// Arbiter for the shared 16-bit async SRAM: VGA fetch vs CPU port.
// Ports: Clk/Reset_n, Cpu_* and Vga_* request sides, Busy, SRAM_* pins.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int VGA_RUN_MAX   = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Cpu_Req,
  input  logic        Cpu_WE,
  input  logic [19:0] Cpu_Addr,
  input  logic [15:0] Cpu_WData,
  output logic [15:0] Cpu_RData,
  output logic        Cpu_Ack,
  input  logic        Vga_Req,
  input  logic [19:0] Vga_Addr,
  output logic [15:0] Vga_RData,
  output logic        Vga_Ack,
  output logic        Busy,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  localparam logic [3:0] LAST    = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] RUN_MAX = 4'(VGA_RUN_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [19:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] vga_rdata_q, vga_rdata_d;
  logic [19:0] sram_addr_q, sram_addr_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        be_n_q, be_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        vga_ack_q, vga_ack_d;
  logic        busy_q, busy_d;
  logic        grant_vga;
  logic        in_acc;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    run_cnt_d   = run_cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    vga_rdata_d = vga_rdata_q;
    grant_vga   = 1'b0;

    case (state_q)
      IDLE: begin
        // VGA wins ties until it has run RUN_MAX times past a waiting CPU.
        grant_vga = Vga_Req &&
                    !(Cpu_Req && run_cnt_q == RUN_MAX);
        if (!Cpu_Req) begin
          run_cnt_d = '0;
        end else if (grant_vga) begin
          run_cnt_d = run_cnt_q + 4'd1;
        end else begin
          run_cnt_d = '0;
        end
        if (Cpu_Req || Vga_Req) begin
          owner_d = grant_vga;
          addr_d  = grant_vga ? Vga_Addr : Cpu_Addr;
          we_d    = !grant_vga && Cpu_WE;
          wdata_d = Cpu_WData;
          beat_d  = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (beat_q == LAST) begin
          state_d = ACK;
          if (!we_q) begin
            if (owner_q) vga_rdata_d = SRAM_DQ;
            else         cpu_rdata_d = SRAM_DQ;
          end
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered from the next-state view so they line up with
  // the state they belong to.
  always_comb begin
    in_acc      = (state_d == ACCESS);
    ce_n_d      = !in_acc;
    be_n_d      = !in_acc;
    oe_n_d      = !(in_acc && !we_d);
    // WE_N releases one beat early to give data/address hold.
    we_n_d      = !(in_acc && we_d && beat_d != LAST);
    dq_oe_d     = in_acc && we_d;
    sram_addr_d = in_acc ? addr_d : sram_addr_q;
    cpu_ack_d   = (state_d == ACK) && !owner_d;
    vga_ack_d   = (state_d == ACK) && owner_d;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      beat_q      <= '0;
      run_cnt_q   <= '0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vga_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      run_cnt_q   <= run_cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      dq_oe_q     <= dq_oe_d;
      cpu_ack_q   <= cpu_ack_d;
      vga_ack_q   <= vga_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? wdata_q : 16'bz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_LB_N = be_n_q;
  assign SRAM_UB_N = be_n_q;
  assign Cpu_RData = cpu_rdata_q;
  assign Vga_RData = vga_rdata_q;
  assign Cpu_Ack   = cpu_ack_q;
  assign Vga_Ack   = vga_ack_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with behavioural async SRAM models.
// Covers reset, CPU/VGA arbitration, run guard, back-to-back, 5-cycle access.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, vga_req;
  logic [19:0] cpu_addr, vga_addr;
  logic [15:0] cpu_wdata, cpu_rdata, vga_rdata;
  logic        cpu_ack, vga_ack, busy;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;

  logic        cpu_req5, cpu_we5;
  logic [19:0] cpu_addr5;
  logic [15:0] cpu_wdata5, cpu_rdata5, vga_rdata5;
  logic        cpu_ack5, vga_ack5, busy5;
  logic [19:0] sram_addr5;
  wire  [15:0] sram_dq5;
  logic        ce5_n, oe5_n, we5_n, lb5_n, ub5_n;

  logic [15:0] mem  [64];
  logic [15:0] mem5 [64];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] idx(input logic [19:0] a);
    return {a[19], a[4:0]};
  endfunction

  sram_arbiter dut (
    .Clk(clk), .Reset_n(rst_n),
    .Cpu_Req(cpu_req), .Cpu_WE(cpu_we),
    .Cpu_Addr(cpu_addr), .Cpu_WData(cpu_wdata),
    .Cpu_RData(cpu_rdata), .Cpu_Ack(cpu_ack),
    .Vga_Req(vga_req), .Vga_Addr(vga_addr),
    .Vga_RData(vga_rdata), .Vga_Ack(vga_ack),
    .Busy(busy), .SRAM_ADDR(sram_addr),
    .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
  );

  sram_arbiter #(.ACCESS_CYCLES(5)) dut5 (
    .Clk(clk), .Reset_n(rst_n),
    .Cpu_Req(cpu_req5), .Cpu_WE(cpu_we5),
    .Cpu_Addr(cpu_addr5), .Cpu_WData(cpu_wdata5),
    .Cpu_RData(cpu_rdata5), .Cpu_Ack(cpu_ack5),
    .Vga_Req(1'b0), .Vga_Addr(20'h0),
    .Vga_RData(vga_rdata5), .Vga_Ack(vga_ack5),
    .Busy(busy5), .SRAM_ADDR(sram_addr5),
    .SRAM_DQ(sram_dq5), .SRAM_CE_N(ce5_n),
    .SRAM_OE_N(oe5_n), .SRAM_WE_N(we5_n),
    .SRAM_LB_N(lb5_n), .SRAM_UB_N(ub5_n)
  );

  assign sram_dq = (!ce_n && !oe_n && we_n)
                 ? mem[idx(sram_addr)] : 16'bz;
  assign sram_dq5 = (!ce5_n && !oe5_n && we5_n)
                  ? mem5[idx(sram_addr5)] : 16'bz;

  always @(posedge we_n)
    if (ce_n === 1'b0) mem[idx(sram_addr)] <= sram_dq;
  always @(posedge we5_n)
    if (ce5_n === 1'b0) mem5[idx(sram_addr5)] <= sram_dq5;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sram_addr !== 20'h0) begin
      errors++;
      $display("FAIL reset_addr got=%h exp=0", sram_addr);
    end
    checks++;
    if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_strobes got=%b exp=11111",
               {ce_n, oe_n, we_n, lb_n, ub_n});
    end
    checks++;
    if ({cpu_ack, vga_ack, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ack_busy got=%b exp=000",
               {cpu_ack, vga_ack, busy});
    end
    checks++;
    if ({cpu_rdata, vga_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h exp=0",
               {cpu_rdata, vga_rdata});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    int we_lo, dq_hi, ack_at;
    we_lo = 0; dq_hi = 0; ack_at = 0;
    cpu_we = 1'b1;
    cpu_addr = 20'h00010;
    cpu_wdata = 16'hBEEF;
    cpu_req = 1'b1;
    for (int n = 1; n <= 10 && ack_at == 0; n++) begin
      @(posedge clk);
      #1;
      if (!we_n) we_lo++;
      if (!ce_n && sram_dq === 16'hBEEF) dq_hi++;
      if (cpu_ack) begin
        ack_at = n;
        cpu_req = 1'b0;
      end
    end
    checks++;
    if (ack_at != 3) begin
      errors++;
      $display("FAIL wr_ack_time got=%0d exp=3", ack_at);
    end
    checks++;
    if (we_lo != 1) begin
      errors++;
      $display("FAIL wr_we_len got=%0d exp=1", we_lo);
    end
    checks++;
    if (dq_hi != 2) begin
      errors++;
      $display("FAIL wr_dq_len got=%0d exp=2", dq_hi);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack_pulse got=%b%b exp=00",
               cpu_ack, busy);
    end
    checks++;
    if (mem[idx(20'h00010)] !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_mem got=%h exp=beef",
               mem[idx(20'h00010)]);
    end
  endtask

  task automatic test_read();
    int oe_lo, ack_at;
    oe_lo = 0; ack_at = 0;
    cpu_we = 1'b0;
    cpu_addr = 20'h00010;
    cpu_req = 1'b1;
    for (int n = 1; n <= 10 && ack_at == 0; n++) begin
      @(posedge clk);
      #1;
      if (!oe_n) oe_lo++;
      if (cpu_ack) begin
        ack_at = n;
        cpu_req = 1'b0;
        checks++;
        if (cpu_rdata !== 16'hBEEF) begin
          errors++;
          $display("FAIL rd_data got=%h exp=beef", cpu_rdata);
        end
        checks++;
        if (ce_n !== 1'b1 || oe_n !== 1'b1) begin
          errors++;
          $display("FAIL rd_ack_strobes got=%b%b exp=11",
                   ce_n, oe_n);
        end
      end
    end
    checks++;
    if (ack_at != 3) begin
      errors++;
      $display("FAIL rd_ack_time got=%0d exp=3", ack_at);
    end
    checks++;
    if (oe_lo != 2) begin
      errors++;
      $display("FAIL rd_oe_len got=%0d exp=2", oe_lo);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_simultaneous();
    int vga_at, cpu_at, cpu_n;
    vga_at = 0; cpu_at = 0; cpu_n = 0;
    cpu_we = 1'b0;
    cpu_addr = 20'h00002;
    vga_addr = 20'h80000;
    cpu_req = 1'b1;
    vga_req = 1'b1;
    for (int n = 1; n <= 20 && cpu_at == 0; n++) begin
      @(posedge clk);
      #1;
      if (vga_ack) begin
        vga_at = n;
        vga_req = 1'b0;
        checks++;
        if (vga_rdata !== 16'h1234) begin
          errors++;
          $display("FAIL sim_vga_data got=%h exp=1234",
                   vga_rdata);
        end
      end
      if (cpu_ack) begin
        cpu_at = n;
        cpu_n++;
        cpu_req = 1'b0;
        checks++;
        if (cpu_rdata !== 16'hA002) begin
          errors++;
          $display("FAIL sim_cpu_data got=%h exp=a002",
                   cpu_rdata);
        end
      end
    end
    checks++;
    if (vga_at != 3 || cpu_at != 7 || cpu_n != 1) begin
      errors++;
      $display("FAIL sim_order got=v%0d c%0d n%0d exp=v3 c7 n1",
               vga_at, cpu_at, cpu_n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_vga_run();
    logic [9:0] seq;
    int cnt, last, bad_gap, first;
    seq = '0; cnt = 0; last = 0; bad_gap = 0; first = 0;
    cpu_we = 1'b0;
    cpu_addr = 20'h00003;
    vga_addr = 20'h80000;
    cpu_req = 1'b1;
    vga_req = 1'b1;
    for (int n = 1; n <= 60 && cnt < 10; n++) begin
      @(posedge clk);
      #1;
      if (vga_ack || cpu_ack) begin
        seq[cnt] = cpu_ack;
        if (cnt == 0) first = n;
        else if (n - last != 4) bad_gap++;
        last = n;
        cnt++;
      end
    end
    cpu_req = 1'b0;
    vga_req = 1'b0;
    checks++;
    if (seq !== 10'b1000010000 || cnt != 10) begin
      errors++;
      $display("FAIL run_pattern got=%b n=%0d exp=1000010000",
               seq, cnt);
    end
    checks++;
    if (bad_gap != 0 || first != 3) begin
      errors++;
      $display("FAIL run_spacing got=gaps%0d first%0d exp=0 3",
               bad_gap, first);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [3];
    int at [3];
    int k;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      got[i] = '0;
      at[i] = 0;
    end
    cpu_we = 1'b0;
    cpu_addr = 20'h00001;
    cpu_req = 1'b1;
    for (int n = 1; n <= 30 && k < 3; n++) begin
      @(posedge clk);
      #1;
      if (cpu_ack) begin
        got[k] = cpu_rdata;
        at[k] = n;
        k++;
        cpu_addr = cpu_addr + 20'd1;
        if (k == 3) cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== 16'hA001 + 16'(i) || at[i] != 3 + 4 * i) begin
        errors++;
        $display("FAIL b2b_%0d got=%h@%0d exp=%h@%0d", i,
                 got[i], at[i], 16'hA001 + 16'(i), 3 + 4 * i);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_write();
    int acks;
    acks = 0;
    cpu_we = 1'b1;
    cpu_addr = 20'h00005;
    cpu_wdata = 16'h5555;
    cpu_req = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (we_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_beat0 got=we%b busy%b exp=0 1",
               we_n, busy);
    end
    #1;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    checks++;
    if ({ce_n, oe_n, we_n} !== 3'b111) begin
      errors++;
      $display("FAIL rst_async_pins got=%b exp=111",
               {ce_n, oe_n, we_n});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      if (cpu_ack || vga_ack) acks++;
    end
    checks++;
    if (acks != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got=acks%0d busy%b exp=0 0",
               acks, busy);
    end
  endtask

  task automatic test_access5();
    int we_lo, oe_lo, ack_at;
    we_lo = 0; oe_lo = 0; ack_at = 0;
    cpu_we5 = 1'b1;
    cpu_addr5 = 20'h00020;
    cpu_wdata5 = 16'h0F0F;
    cpu_req5 = 1'b1;
    for (int n = 1; n <= 15 && ack_at == 0; n++) begin
      @(posedge clk);
      #1;
      if (!we5_n) we_lo++;
      if (cpu_ack5) begin
        ack_at = n;
        cpu_req5 = 1'b0;
      end
    end
    checks++;
    if (ack_at != 6 || we_lo != 4) begin
      errors++;
      $display("FAIL ac5_write got=ack%0d we%0d exp=6 4",
               ack_at, we_lo);
    end
    @(posedge clk);
    #1;
    ack_at = 0;
    cpu_we5 = 1'b0;
    cpu_req5 = 1'b1;
    for (int n = 1; n <= 15 && ack_at == 0; n++) begin
      @(posedge clk);
      #1;
      if (!oe5_n) oe_lo++;
      if (cpu_ack5) begin
        ack_at = n;
        cpu_req5 = 1'b0;
      end
    end
    checks++;
    if (ack_at != 6 || oe_lo != 5) begin
      errors++;
      $display("FAIL ac5_read got=ack%0d oe%0d exp=6 5",
               ack_at, oe_lo);
    end
    checks++;
    if (cpu_rdata5 !== 16'h0F0F) begin
      errors++;
      $display("FAIL ac5_data got=%h exp=0f0f", cpu_rdata5);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    cpu_req5 = 1'b0; cpu_we5 = 1'b0;
    cpu_addr5 = '0; cpu_wdata5 = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'h0;
      mem5[i] = 16'h0;
    end
    mem[idx(20'h80000)] = 16'h1234;
    mem[idx(20'h00001)] = 16'hA001;
    mem[idx(20'h00002)] = 16'hA002;
    mem[idx(20'h00003)] = 16'hA003;
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_vga_run();
    test_back_to_back();
    test_reset_mid_write();
    test_access5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the board's single external 16-bit asynchronous SRAM between the eLC-3 CPU memory port and the VGA framebuffer fetch unit. It sits between the datapath's memory interface (MAR/MDR, MIO_EN, R_W) and the SRAM pins. It serialises accesses, generates the SRAM strobes with a fixed access length, and returns read data with a one-cycle acknowledge. VGA has priority, with a bounded-run guard so the CPU never starves.

## Interface
- ACCESS_CYCLES, 2, cycles each SRAM access holds address/strobes; legal 2..15
- VGA_RUN_MAX, 4, max consecutive VGA grants while Cpu_Req is pending; legal 1..15
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous, active-low reset
- Cpu_Req  in  1  CPU access request; held until Cpu_Ack
- Cpu_WE  in  1  1 = write, 0 = read; stable while Cpu_Req
- Cpu_Addr  in  20  CPU word address
- Cpu_WData  in  16  CPU write data
- Cpu_RData  out  16  CPU read data; valid in the Cpu_Ack cycle
- Cpu_Ack  out  1  one-cycle completion pulse
- Vga_Req  in  1  VGA read request; held until Vga_Ack
- Vga_Addr  in  20  VGA word address
- Vga_RData  out  16  VGA read data; valid in the Vga_Ack cycle
- Vga_Ack  out  1  one-cycle completion pulse
- Busy  out  1  high in ACCESS and ACK states
- SRAM_ADDR  out  20  SRAM address
- SRAM_DQ  inout  16  SRAM data; driven only during write accesses
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  SRAM strobes, active-low

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE: arbitrate on the current Cpu_Req/Vga_Req. Both idle -> stay in IDLE.
  - Only one requester active -> grant it.
  - Both active -> grant VGA, unless run_cnt == VGA_RUN_MAX; then grant CPU.
- On grant, latch owner, address, we, and wdata into internal registers, then go to ACCESS. The request-side inputs are not used again for this access.
- run_cnt (4 bits):
  - +1 on a VGA grant made while Cpu_Req=1.
  - Cleared on a CPU grant.
  - Cleared at any arbitration where Cpu_Req=0.
- ACCESS: lasts exactly ACCESS_CYCLES cycles (beat counter 0..ACCESS_CYCLES-1).
  - Every beat: SRAM_CE_N=0, LB_N=UB_N=0, SRAM_ADDR=latched address.
  - Read: OE_N=0 for all beats, WE_N=1, DQ at hi-Z. SRAM_DQ is sampled into the owner's RData register on the clock edge that ends the last beat.
  - Write: OE_N=1. DQ is driven with latched wdata for all beats. WE_N=0 for beats 0..ACCESS_CYCLES-2 and 1 in the last beat, which gives data/address hold.
  - After the last beat, go to ACK.
- ACK: all strobes deasserted, DQ at hi-Z. The owner's Ack=1 for this single cycle. Its RData holds the read value (unchanged on writes). Next state is always IDLE.
- Requester rule: a requester may drop Req on the edge where it sees Ack. Req still high in the following IDLE cycle counts as a new request.
- RData registers hold their value until the next read completes for that owner.
- Reset (asynchronous, any state): state=IDLE, run_cnt=0. No Ack is issued and any in-flight access is abandoned.
  - Output reset values: SRAM_ADDR=0; CE_N, OE_N, WE_N, LB_N, UB_N=1; DQ hi-Z; Cpu_Ack=Vga_Ack=0; Cpu_RData=Vga_RData=0; Busy=0.

## Timing
- All SRAM pins come from registers. No combinational path runs from request inputs to pins or acks.
- Request sampled in IDLE at edge t:
  - ACCESS occupies cycles t+1 .. t+ACCESS_CYCLES.
  - Ack at cycle t+ACCESS_CYCLES+1.
  - Next arbitration at t+ACCESS_CYCLES+2.
- Back-to-back throughput: one access per ACCESS_CYCLES+2 cycles (4 cycles at default).
- Worst-case CPU wait with VGA continuously requesting: VGA_RUN_MAX accesses plus the one in flight.
- Simultaneous Req arrival with run_cnt < VGA_RUN_MAX: VGA wins. The CPU request stays pending and is not lost.
- Reset_n deasserted mid-ACCESS: CE_N/WE_N rise asynchronously, and the first legal access starts no earlier than one cycle after Reset_n rises.

## Test plan
- Reset, with defaults: check all pins take their reset values. CPU write Addr=0x00010, WData=0xBEEF -> WE_N low for exactly 1 cycle, DQ=0xBEEF for 2 cycles, Cpu_Ack at t+3. A following CPU read of 0x00010 -> Cpu_RData=0xBEEF with Cpu_Ack at t+3.
- Cpu_Req and Vga_Req rise on the same edge (Vga_Addr=0x80000 preloaded with 0x1234) -> VGA served first, Vga_RData=0x1234. CPU served in the next arbitration; no Cpu_Ack is dropped.
- Vga_Req held high continuously, Cpu_Req high -> exactly 4 Vga_Acks, then 1 Cpu_Ack, then VGA again. The pattern repeats.
- Cpu_Req held high across Cpu_Ack, addresses 0x00001..0x00003 -> three reads at a 4-cycle spacing. The acks carry the three memory words in order.
- Reset_n pulsed low during beat 0 of a write -> WE_N returns to 1 immediately and no Ack is seen. Memory at that address is either unchanged or new data; the bench checks only the pin levels and FSM = IDLE.
- ACCESS_CYCLES=5 -> read Ack at t+6 and OE_N low for 5 cycles. On a write, WE_N is low for 4 cycles.
